lc3_fetch_sequencer: RTL

- Control FSM that drives the LC-3 instruction-fetch datapath: PC load enable, IR load enable and PC source select.
- Sequences each instruction through IRAM wait, IR load and issue, then waits for the execute stage.
- Commits next PC as sequential (PC+1) or redirect (Y) from execute feedback.
- Detects HALT (TRAP x25) and parks the fetch unit.

---
 rtl/lc3_fetch_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lc3_fetch_sequencer.sv
// ============================================================================
//  Module      : lc3_fetch_sequencer
//  Description : LC-3 fetch control FSM: WAIT -> LOAD -> ISSUE -> EXEC, parks on HALT.
//                Optional perf counters enabled by defining LC3_FETCH_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lc3_fetch_sequencer #(
    parameter int         IMEM_LATENCY = 1,
    parameter logic [7:0] HALT_VECTOR  = 8'h25
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] IR,
    input  logic        EX_DONE,
    input  logic        BR_TAKEN,
    input  logic        STALL,
    output logic        PC_LE,
    output logic        IR_LE,
    output logic        PC_CONTROL,
    output logic        IR_VALID,
    output logic        HALTED
`ifdef LC3_FETCH_PERF_EN
    ,
    output logic [15:0] RETIRED_CNT,
    output logic [15:0] REDIRECT_CNT,
    output logic [15:0] STALL_CNT
`endif
);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [1:0] c_LAT_LAST = 2'(IMEM_LATENCY - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [1:0] r_lat_cnt;
    logic [1:0] w_lat_nxt;
    logic       w_is_halt;
    logic       w_unused_ir;

    assign w_is_halt   = (IR[15:12] == 4'hF) && (IR[7:0] == HALT_VECTOR);
    assign w_unused_ir = ^IR[11:8];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_WAIT;
            r_lat_cnt <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = 2'd0;
        case (r_state)
            S_WAIT: begin
                w_lat_nxt = r_lat_cnt;
                if (!STALL) begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        w_state_nxt = S_LOAD;
                        w_lat_nxt   = 2'd0;
                    end else begin
                        w_lat_nxt = r_lat_cnt + 2'd1;
                    end
                end
            end
            S_LOAD:  w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC:  if (EX_DONE) w_state_nxt = S_WAIT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Strobes are gated by RESET so an aborted cycle never loads PC or IR.
    always_comb begin
        PC_LE      = 1'b0;
        IR_LE      = 1'b0;
        PC_CONTROL = 1'b0;
        IR_VALID   = 1'b0;
        HALTED     = 1'b0;
        case (r_state)
            S_LOAD: IR_LE = !RESET;
            S_EXEC: begin
                IR_VALID   = 1'b1;
                PC_LE      = EX_DONE && !RESET;
                PC_CONTROL = EX_DONE && BR_TAKEN && !RESET;
            end
            S_HALT:  HALTED = 1'b1;
            default: ;
        endcase
    end

`ifdef LC3_FETCH_PERF_EN
    logic [15:0] r_retired_cnt;
    logic [15:0] r_redirect_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_retired_cnt  <= 16'd0;
            r_redirect_cnt <= 16'd0;
            r_stall_cnt    <= 16'd0;
        end else begin
            if (r_state == S_EXEC && EX_DONE)
                r_retired_cnt <= r_retired_cnt + 16'd1;
            if (r_state == S_EXEC && EX_DONE && BR_TAKEN)
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            if (r_state == S_WAIT && STALL)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign RETIRED_CNT  = r_retired_cnt;
    assign REDIRECT_CNT = r_redirect_cnt;
    assign STALL_CNT    = r_stall_cnt;
`endif

endmodule

`default_nettype wire
